imem_arbiter: RTL and testbench

Single-port arbiter and boot sequencer for the instruction memory. It shares one synchronous-read memory port between the core's fetch stage and a program loader/debug port. After reset it holds fetch off (BOOT) until the loader signals completion, then arbitrates between the two with an anti-starvation rule (RUN). It sits between the fetch stage, the loader and the instruction memory array.

---
 rtl/imem_arbiter.sv | 140 ++++++++++++++
 tb/tb_imem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous-read instruction memory port between
// the fetch stage and the program loader. After reset only the loader is
// served (BOOT) until ld_done; then both are arbitrated with loader priority
// and a starvation guard that forces a fetch grant after MAX_STALL loader
// grants while fetch waits (RUN).
// Optional feature macro: IMEM_WRITE_PROTECT_EN -- when defined, loader writes
// in RUN are granted but dropped, and ld_err pulses for that cycle.
module imem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_STALL = 4
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_done,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              booted
);

    localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] stall_cnt;
    logic [3:0] stall_nxt;
    logic       f_pend;
    logic       ld_pend;
    logic       wr_block;

    // Pick at most one grant per cycle and compute next state / stall count;
    // nothing is granted while reset is asserted
    always_comb begin
        state_nxt = state;
        stall_nxt = stall_cnt;
        f_gnt     = 1'b0;
        ld_gnt    = 1'b0;
        if (!SYS_reset) begin
            unique case (state)
                BOOT: begin
                    ld_gnt    = ld_req;
                    stall_nxt = '0;
                    if (ld_done) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (f_req && ld_req) begin
                        if (stall_cnt >= STALL_LIMIT) begin
                            f_gnt = 1'b1;
                        end else begin
                            ld_gnt = 1'b1;
                        end
                    end else begin
                        f_gnt  = f_req;
                        ld_gnt = ld_req;
                    end
                    // Count only cycles where fetch asked and lost
                    if (f_req && !f_gnt) begin
                        stall_nxt = (stall_cnt >= STALL_LIMIT) ? STALL_LIMIT
                                                              : stall_cnt + 4'd1;
                    end else begin
                        stall_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = BOOT;
                end
            endcase
        end
    end

    // Decide whether a granted loader write must be suppressed
    always_comb begin
        wr_block = 1'b0;
`ifdef IMEM_WRITE_PROTECT_EN
        wr_block = (state == RUN) && ld_gnt && ld_we;
`endif
    end

    // Drive the memory port from the winning requester in the grant cycle
    always_comb begin
        mem_en    = (f_gnt || ld_gnt) && !wr_block;
        mem_we    = ld_gnt && ld_we && !wr_block;
        mem_addr  = '0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (ld_gnt && !wr_block) begin
            mem_addr = ld_addr;
        end
        mem_wdata = mem_we ? ld_wdata : '0;
        ld_err    = wr_block;
    end

    // State, stall counter and owner of the read returning next cycle
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state     <= BOOT;
            stall_cnt <= '0;
            f_pend    <= 1'b0;
            ld_pend   <= 1'b0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_nxt;
            f_pend    <= f_gnt;
            ld_pend   <= ld_gnt && !ld_we;
        end
    end

    // Route returning read data to its owner; data is zero when not valid
    always_comb begin
        f_rvalid  = f_pend;
        ld_rvalid = ld_pend;
        f_rdata   = f_pend  ? mem_rdata : '0;
        ld_rdata  = ld_pend ? mem_rdata : '0;
        booted    = (state == RUN);
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios plus randomized traffic for
// imem_arbiter, checked against a behavioural model of the arbitration rules
// and a shadow copy of the memory contents.
module tb_imem_arbiter;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int MAX_STALL = 4;
    localparam int DEPTH     = 1 << ADDR_W;
`ifdef IMEM_WRITE_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic              SYS_clk = 1'b0;
    logic              SYS_reset;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_done;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              booted;

    int total = 0;
    int bad   = 0;

    always #5 SYS_clk = ~SYS_clk;

    imem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_STALL(MAX_STALL)
    ) dut (
        .SYS_clk  (SYS_clk),
        .SYS_reset(SYS_reset),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .ld_req   (ld_req),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata),
        .ld_done  (ld_done),
        .ld_gnt   (ld_gnt),
        .ld_rvalid(ld_rvalid),
        .ld_rdata (ld_rdata),
        .ld_err   (ld_err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .booted   (booted)
    );

    // Synchronous-read memory array attached to the DUT port
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge SYS_clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Reference model state
    bit                m_run;
    int                m_wait;
    bit                p_f, p_ld;
    logic [DATA_W-1:0] p_data;
    logic [DATA_W-1:0] ref_mem [DEPTH];

    // Expected values for the current cycle
    bit                e_fg, e_lg, e_en, e_we, e_err, e_boot, e_frv, e_lrv;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_frd, e_lrd;
    logic [7:0]        exp_ctl, obs_ctl;

    // Evaluate the rules for the current inputs, then advance the model
    // past the coming clock edge. Call at the falling edge.
    task automatic sample();
        bit write, blocked;
        @(negedge SYS_clk);
        e_frv  = p_f;
        e_lrv  = p_ld;
        e_frd  = p_f  ? p_data : '0;
        e_lrd  = p_ld ? p_data : '0;
        e_boot = m_run;
        e_fg = 1'b0;
        e_lg = 1'b0;
        if (!SYS_reset) begin
            if (!m_run) begin
                e_lg = ld_req;
            end else if (ld_req && f_req) begin
                e_fg = (m_wait >= MAX_STALL);
                e_lg = !e_fg;
            end else begin
                e_fg = f_req;
                e_lg = ld_req;
            end
        end
        write   = e_lg && ld_we;
        blocked = PROTECT && m_run && write;
        e_en    = (e_fg || e_lg) && !blocked;
        e_we    = write && !blocked;
        e_err   = blocked;
        e_addr  = e_fg ? f_addr : ((e_lg && !blocked) ? ld_addr : '0);
        e_wdata = e_we ? ld_wdata : '0;
        exp_ctl = {e_fg, e_lg, e_en, e_we, e_err, e_boot, e_frv, e_lrv};
        obs_ctl = {f_gnt, ld_gnt, mem_en, mem_we, ld_err, booted, f_rvalid, ld_rvalid};
        if (SYS_reset) begin
            m_run = 1'b0; m_wait = 0; p_f = 1'b0; p_ld = 1'b0;
        end else begin
            p_f  = e_fg;
            p_ld = e_lg && !ld_we;
            if (e_fg)      p_data = ref_mem[f_addr];
            else if (e_lg) p_data = ref_mem[ld_addr];
            if (e_we) ref_mem[ld_addr] = ld_wdata;
            if (m_run && f_req && !e_fg) m_wait = (m_wait + 1 > MAX_STALL) ? MAX_STALL : m_wait + 1;
            else                         m_wait = 0;
            if (!m_run && ld_done) m_run = 1'b1;
        end
    endtask

    task automatic next_cycle();
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_req = 1'b0; f_addr = '0; ld_req = 1'b0; ld_we = 1'b0;
        ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        SYS_reset = 1'b1;
        next_cycle();
        sample();
        next_cycle();
        SYS_reset = 1'b0;
        sample();
        total++;
        if (obs_ctl !== 8'h00) begin
            bad++; $display("FAIL reset_ctl: got %b want 00000000", obs_ctl);
        end
        total++;
        if ({mem_addr, mem_wdata, f_rdata, ld_rdata} !== '0) begin
            bad++; $display("FAIL reset_data: addr %h wdata %h frd %h lrd %h want all 0",
                            mem_addr, mem_wdata, f_rdata, ld_rdata);
        end
        next_cycle();
        f_req = 1'b1; f_addr = 10'd5;
        for (int i = 0; i < 3; i++) begin
            sample();
            total++;
            if ({f_gnt, mem_en, booted} !== 3'b000) begin
                bad++; $display("FAIL boot_fetch_blocked c%0d: gnt/en/booted got %b want 000",
                                i, {f_gnt, mem_en, booted});
            end
            next_cycle();
        end
    endtask

    task automatic test_boot_load();
        // Loader write while fetch keeps asking
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd3; ld_wdata = 32'h0050_0093;
        sample();
        total++;
        if ({f_gnt, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b0111, 10'd3, 32'h0050_0093}) begin
            bad++; $display("FAIL boot_write: fg/lg/en/we %b addr %0d wdata %h want 0111 3 00500093",
                            {f_gnt, ld_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        next_cycle();
        // ld_done together with another loader write: still served in BOOT
        ld_done = 1'b1; ld_addr = 10'd7; ld_wdata = 32'h1234_5678;
        f_addr = 10'd3;
        sample();
        total++;
        if ({f_gnt, ld_gnt, mem_we, booted} !== 4'b0110) begin
            bad++; $display("FAIL done_with_req: fg/lg/we/booted got %b want 0110",
                            {f_gnt, ld_gnt, mem_we, booted});
        end
        next_cycle();
        ld_done = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
        sample();
        total++;
        if ({f_gnt, mem_en, mem_we, booted, mem_addr} !== {4'b1101, 10'd3}) begin
            bad++; $display("FAIL run_fetch_gnt: fg/en/we/booted %b addr %0d want 1101 3",
                            {f_gnt, mem_en, mem_we, booted}, mem_addr);
        end
        next_cycle();
        f_req = 1'b0;
        sample();
        total++;
        if ({f_rvalid, ld_rvalid, f_rdata} !== {2'b10, 32'h0050_0093}) begin
            bad++; $display("FAIL boot_fetch_data: frv/lrv %b rdata %h want 10 00500093",
                            {f_rvalid, ld_rvalid}, f_rdata);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        bit want_f;
        f_req = 1'b1; ld_req = 1'b1; ld_we = 1'b0;
        for (int i = 0; i < 2 * (MAX_STALL + 1); i++) begin
            f_addr  = 10'($urandom_range(0, 15));
            ld_addr = 10'($urandom_range(0, 15));
            sample();
            want_f = ((i % (MAX_STALL + 1)) == MAX_STALL);
            total++;
            if ({f_gnt, ld_gnt} !== {want_f, !want_f}) begin
                bad++; $display("FAIL starve_seq c%0d: fg/lg got %b want %b",
                                i, {f_gnt, ld_gnt}, {want_f, !want_f});
            end
            total++;
            if ({obs_ctl, mem_addr, f_rdata, ld_rdata} !== {exp_ctl, e_addr, e_frd, e_lrd}) begin
                bad++; $display("FAIL starve_model c%0d: ctl %b addr %0d frd %h lrd %h want %b %0d %h %h",
                                i, obs_ctl, mem_addr, f_rdata, ld_rdata, exp_ctl, e_addr, e_frd, e_lrd);
            end
            next_cycle();
        end
        idle_inputs();
        sample();
        next_cycle();
    endtask

    task automatic test_ld_read();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd3;
        sample();
        total++;
        if ({ld_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 10'd3}) begin
            bad++; $display("FAIL ld_read_gnt: lg/en/we %b addr %0d want 110 3",
                            {ld_gnt, mem_en, mem_we}, mem_addr);
        end
        next_cycle();
        ld_req = 1'b0;
        sample();
        total++;
        if ({ld_rvalid, f_rvalid, ld_rdata, f_rdata} !== {2'b10, 32'h0050_0093, 32'h0}) begin
            bad++; $display("FAIL ld_read_data: lrv/frv %b lrd %h frd %h want 10 00500093 0",
                            {ld_rvalid, f_rvalid}, ld_rdata, f_rdata);
        end
        next_cycle();
    endtask

    task automatic test_run_write();
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] want;
`ifdef IMEM_WRITE_PROTECT_EN
        wa = 10'd3; want = 32'h0050_0093;
`else
        wa = 10'd9; want = 32'hFFFF_FFFF;
`endif
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = wa; ld_wdata = 32'hFFFF_FFFF;
        sample();
        total++;
        if ({ld_gnt, ld_err, mem_en, mem_we} !== {1'b1, PROTECT, !PROTECT, !PROTECT}) begin
            bad++; $display("FAIL run_write: lg/err/en/we got %b want %b",
                            {ld_gnt, ld_err, mem_en, mem_we}, {1'b1, PROTECT, !PROTECT, !PROTECT});
        end
        next_cycle();
        ld_req = 1'b0; ld_we = 1'b0; f_req = 1'b1; f_addr = wa;
        sample();
        total++;
        if ({f_gnt, ld_err, ld_rvalid} !== 3'b100) begin
            bad++; $display("FAIL run_write_after: fg/err/lrv got %b want 100",
                            {f_gnt, ld_err, ld_rvalid});
        end
        next_cycle();
        f_req = 1'b0;
        sample();
        total++;
        if ({f_rvalid, f_rdata} !== {1'b1, want}) begin
            bad++; $display("FAIL run_write_readback: frv %b rdata %h want 1 %h",
                            f_rvalid, f_rdata, want);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        f_req = 1'b1; f_addr = 10'd3;
        sample();
        total++;
        if (f_gnt !== 1'b1) begin
            bad++; $display("FAIL mid_pre_gnt: f_gnt got %b want 1", f_gnt);
        end
        next_cycle();
        SYS_reset = 1'b1; f_req = 1'b0;
        sample();
        next_cycle();
        SYS_reset = 1'b0; f_req = 1'b1;
        sample();
        total++;
        if ({f_rvalid, f_rdata, booted, f_gnt, mem_en} !== {1'b0, 32'h0, 3'b000}) begin
            bad++; $display("FAIL mid_reset: frv %b rdata %h booted/fg/en %b want 0 0 000",
                            f_rvalid, f_rdata, {booted, f_gnt, mem_en});
        end
        next_cycle();
    endtask

    // Random traffic with hold-until-grant requesters, ld_done pulses and
    // occasional resets
    task automatic test_random(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sample();
            total++;
            if (obs_ctl !== exp_ctl) begin
                bad++; $display("FAIL %s_ctl c%0d: got %b want %b", tag, i, obs_ctl, exp_ctl);
            end
            total++;
            if ({mem_addr, mem_wdata} !== {e_addr, e_wdata}) begin
                bad++; $display("FAIL %s_port c%0d: addr %0d wdata %h want %0d %h",
                                tag, i, mem_addr, mem_wdata, e_addr, e_wdata);
            end
            total++;
            if ({f_rdata, ld_rdata} !== {e_frd, e_lrd}) begin
                bad++; $display("FAIL %s_rdata c%0d: frd %h lrd %h want %h %h",
                                tag, i, f_rdata, ld_rdata, e_frd, e_lrd);
            end
            next_cycle();
            if (!f_req || e_fg) begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = 10'($urandom_range(0, 15));
            end
            if (!ld_req || e_lg) begin
                ld_req   = $urandom_range(0, 1) == 1;
                ld_we    = ($urandom_range(0, 2) == 0);
                ld_addr  = 10'($urandom_range(0, 15));
                ld_wdata = $urandom;
            end
            ld_done   = ($urandom_range(0, 39) == 0);
            SYS_reset = ($urandom_range(0, 149) == 0);
        end
        SYS_reset = 1'b0;
        idle_inputs();
        sample();
        next_cycle();
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            mem[a]     = $urandom;
            ref_mem[a] = mem[a];
        end
        m_run = 1'b0; m_wait = 0; p_f = 1'b0; p_ld = 1'b0; p_data = '0;
        idle_inputs();
        SYS_reset = 1'b1;
        @(posedge SYS_clk);
        #1;
        test_reset();
        test_boot_load();
        test_starvation();
        test_ld_read();
        test_run_write();
        test_random(300, "rand_run");
        test_reset_mid();
        test_random(300, "rand_boot");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
